// File: rtl/os_array_pkg.sv
// Shared types and helpers for the output-stationary array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package os_array_pkg;

    localparam int ELEM_W = 32;

    // One 16.16 fixed-point matrix element; moved, never interpreted.
    typedef logic [ELEM_W-1:0] elem_t;

    // Sequencer state encoding.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FEED    = 3'd1;
    localparam state_t ST_DRAIN   = 3'd2;
    localparam state_t ST_SHIFT   = 3'd3;
    localparam state_t ST_COLLECT = 3'd4;

    // Element (r,c) of a row-major flat matrix lives at element slot r*n+c.
    function automatic int unsigned flat_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/os_array_sequencer_feeder.sv
// Skewed wavefront lane generator for the N x N output-stationary array.
// Latency: combinational; the parent registers the lanes.
// Backpressure: none; one wavefront step per evaluated step index.
module os_skew_feeder
    import os_array_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 32,
    parameter int T_W    = 8
) (
    input  logic [T_W-1:0]          t,
    input  logic                    active,
    input  logic [N*N*DATA_W-1:0]   iact_mat,
    input  logic [N*N*DATA_W-1:0]   weight_mat,
    output logic [N*DATA_W-1:0]     iact_v,
    output logic [N*DATA_W-1:0]     weight_v,
    output logic [N-1:0]            valid_v
);

    // Lane i carries inner index k = t - i; matching on (i,k) keeps every select constant.
    always_comb begin
        iact_v   = '0;
        weight_v = '0;
        valid_v  = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (active && (int'(t) == i + k)) begin
                    valid_v[i] = 1'b1;
                    iact_v[i*DATA_W +: DATA_W]   = iact_mat[flat_idx(i, k, N)*DATA_W +: DATA_W];
                    weight_v[i*DATA_W +: DATA_W] = weight_mat[flat_idx(k, i, N)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/os_array_sequencer.sv
// Runs one product on the N x N output-stationary array: feed, drain, shift, collect.
// Latency: start accept to shift_acc = 2N-1 + DRAIN_CYCLES + 1 cycles; collect bounded by TIMEOUT_CYCLES.
// Backpressure: start accepted only while ready (IDLE); out_valid has no stall, missing beats end in timeout.
module os_array_sequencer
    import os_array_pkg::*;
#(
    parameter int N              = 3,
    parameter int DATA_W         = 32,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    ready,
    input  logic [N*N*DATA_W-1:0]   iact_mat,
    input  logic [N*N*DATA_W-1:0]   weight_mat,
    output logic [N*DATA_W-1:0]     iact_in,
    output logic [N*DATA_W-1:0]     weight_in,
    output logic [N-1:0]            in_valid,
    output logic                    shift_acc,
    input  logic [DATA_W-1:0]       data_out,
    input  logic                    out_valid,
    output logic [N*N*DATA_W-1:0]   result_mat,
    output logic                    done,
    output logic                    error
);

    localparam int NN = N * N;
    localparam int MW = NN * DATA_W;
    localparam int LW = N * DATA_W;
    // One width wide enough for the feed step, drain count, collect timer and beat count.
    localparam int CW = $clog2(TIMEOUT_CYCLES + DRAIN_CYCLES + 2*N + NN + 1);

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] LAST_STEP  = CW'(2*N - 2);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] LAST_WAIT  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(NN - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   step_q, step_d;     // feed step t, drain count, or collect timer
    logic [CW-1:0]   beat_q, beat_d;
    logic [MW-1:0]   iact_lat_q, iact_lat_d;
    logic [MW-1:0]   weight_lat_q, weight_lat_d;
    logic [LW-1:0]   iact_in_q, iact_in_d;
    logic [LW-1:0]   weight_in_q, weight_in_d;
    logic [N-1:0]    in_valid_q, in_valid_d;
    logic            shift_q, shift_d;
    logic [MW-1:0]   result_q, result_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [LW-1:0]   feed_iact;
    logic [LW-1:0]   feed_weight;
    logic [N-1:0]    feed_valid;

    os_skew_feeder #(
        .N      (N),
        .DATA_W (DATA_W),
        .T_W    (CW)
    ) u_feeder (
        .t          (step_q),
        .active     (state_q == ST_FEED),
        .iact_mat   (iact_lat_q),
        .weight_mat (weight_lat_q),
        .iact_v     (feed_iact),
        .weight_v   (feed_weight),
        .valid_v    (feed_valid)
    );

    // Next-state, counters, matrix latch, collector and registered array-side outputs.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        beat_d       = beat_q;
        iact_lat_d   = iact_lat_q;
        weight_lat_d = weight_lat_q;
        iact_in_d    = feed_iact;
        weight_in_d  = feed_weight;
        in_valid_d   = feed_valid;
        shift_d      = 1'b0;
        result_d     = result_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FEED;
                    iact_lat_d   = iact_mat;
                    weight_lat_d = weight_mat;
                    step_d       = '0;
                    beat_d       = '0;
                    result_d     = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                end
            end
            ST_FEED: begin
                if (step_q == LAST_STEP) begin
                    state_d = ST_DRAIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + ONE;
                end
            end
            ST_DRAIN: begin
                if (step_q == LAST_DRAIN) begin
                    state_d = ST_SHIFT;
                    step_d  = '0;
                end else begin
                    step_d = step_q + ONE;
                end
            end
            ST_SHIFT: begin
                shift_d = 1'b1;
                state_d = ST_COLLECT;
                step_d  = '0;
                beat_d  = '0;
            end
            ST_COLLECT: begin
                // The array drains bottom-right first, so beat b fills slot NN-1-b.
                if (out_valid) begin
                    for (int b = 0; b < NN; b++) begin
                        if (beat_q == CW'(b)) begin
                            result_d[(NN-1-b)*DATA_W +: DATA_W] = data_out;
                        end
                    end
                    beat_d = beat_q + ONE;
                end
                if (out_valid && (beat_q == LAST_BEAT)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b0;
                end else if (step_q == LAST_WAIT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    step_d = step_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any run in flight and clears the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            beat_q       <= '0;
            iact_lat_q   <= '0;
            weight_lat_q <= '0;
            iact_in_q    <= '0;
            weight_in_q  <= '0;
            in_valid_q   <= '0;
            shift_q      <= 1'b0;
            result_q     <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            beat_q       <= beat_d;
            iact_lat_q   <= iact_lat_d;
            weight_lat_q <= weight_lat_d;
            iact_in_q    <= iact_in_d;
            weight_in_q  <= weight_in_d;
            in_valid_q   <= in_valid_d;
            shift_q      <= shift_d;
            result_q     <= result_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign iact_in    = iact_in_q;
    assign weight_in  = weight_in_q;
    assign in_valid   = in_valid_q;
    assign shift_acc  = shift_q;
    assign result_mat = result_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_os_array_sequencer.sv
// Self-checking bench: array stand-in rebuilt from the observed wavefront, cycle model, scoreboard.
// Latency: checks every cycle on the falling edge.
// Backpressure: out_valid beats driven with random gaps; stub mode withholds them.
module tb_os_array_sequencer;
    import os_array_pkg::*;

    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int DRAIN = 4;
    localparam int TMO   = 64;
    localparam int MW    = N * N * DW;
    localparam int LAT   = 2*N - 1 + DRAIN + 1;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           ready;
    logic [MW-1:0]  iact_mat;
    logic [MW-1:0]  weight_mat;
    logic [N*DW-1:0] iact_in;
    logic [N*DW-1:0] weight_in;
    logic [N-1:0]   in_valid;
    logic           shift_acc;
    logic [DW-1:0]  data_out  = '0;
    logic           out_valid = 1'b0;
    logic [MW-1:0]  result_mat;
    logic           done;
    logic           error;

    always #5 clock = ~clock;

    os_array_sequencer #(
        .N              (N),
        .DATA_W         (DW),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .iact_mat   (iact_mat),
        .weight_mat (weight_mat),
        .iact_in    (iact_in),
        .weight_in  (weight_in),
        .in_valid   (in_valid),
        .shift_acc  (shift_acc),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .result_mat (result_mat),
        .done       (done),
        .error      (error)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit stub_mode = 1'b0;
    bit junk_mode = 1'b0;
    bit rst_seen = 1'b1;

    // Behavioural model state
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err  = 1'b0;
    int            m_k    = 0;
    int            m_beats = 0;
    logic [MW-1:0] m_a = '0;
    logic [MW-1:0] m_w = '0;
    logic [MW-1:0] m_res = '0;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic elem_t fx(input elem_t a, input elem_t b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[47:16];
    endfunction

    function automatic logic [MW-1:0] ref_prod(input logic [MW-1:0] a, input logic [MW-1:0] w);
        logic [MW-1:0] r;
        elem_t acc;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) acc = acc + fx(a[(i*N+k)*DW +: DW], w[(k*N+j)*DW +: DW]);
                r[(i*N+j)*DW +: DW] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] r;
        elem_t v;
        for (int e = 0; e < N*N; e++) begin
            v = (elem_t'($urandom_range(0, 15)) << 16) | (elem_t'($urandom_range(0, 1)) << 15);
            if ($urandom_range(0, 3) == 0) v = -v;
            r[e*DW +: DW] = v;
        end
        return r;
    endfunction

    // Model: a run is a fixed timeline measured from the accepting edge, then a beat count.
    always @(posedge clock) begin
        int d;
        cyc++;
        rst_seen = reset;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_res = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1; m_k = cyc; m_a = iact_mat; m_w = weight_mat;
                m_done = 1'b0; m_err = 1'b0; m_res = '0; m_beats = 0;
            end
        end else begin
            d = cyc - m_k;
            if (d > LAT) begin
                if (out_valid) begin
                    m_res[(N*N-1-m_beats)*DW +: DW] = data_out;
                    m_beats++;
                end
                if (m_beats == N*N) begin
                    m_busy = 1'b0; m_done = 1'b1; m_err = 1'b0;
                end else if (d == LAT + TMO) begin
                    m_busy = 1'b0; m_done = 1'b1; m_err = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output against the model each cycle.
    always @(negedge clock) begin
        logic [N-1:0]    ev;
        logic [N*DW-1:0] ei;
        logic [N*DW-1:0] ew;
        bit esh;
        int d;
        int t;
        if (chk_en) begin
            ev = '0; ei = '0; ew = '0; esh = 1'b0;
            if (m_busy) begin
                d = cyc - m_k;
                if (d >= 1 && d <= 2*N-1) begin
                    t = d - 1;
                    for (int i = 0; i < N; i++) begin
                        if (t >= i && t <= i + N - 1) begin
                            ev[i] = 1'b1;
                            ei[i*DW +: DW] = m_a[(i*N + t - i)*DW +: DW];
                            ew[i*DW +: DW] = m_w[((t - i)*N + i)*DW +: DW];
                        end
                    end
                end
                esh = (d == LAT);
            end
            check("ready",     MW'(ready),     MW'(!m_busy));
            check("done",      MW'(done),      MW'(m_done));
            check("error",     MW'(error),     MW'(m_err));
            check("in_valid",  MW'(in_valid),  MW'(ev));
            check("iact_in",   MW'(iact_in),   MW'(ei));
            check("weight_in", MW'(weight_in), MW'(ew));
            check("shift_acc", MW'(shift_acc), MW'(esh));
            check("result",    result_mat,     m_res);
        end
    end

    // Array stand-in: record the wavefront, form the products on shift_acc, stream them back reversed.
    elem_t rec_i [N][2*N-1];
    elem_t rec_w [N][2*N-1];
    elem_t emit_q [$];
    logic [N-1:0] prev_v = '0;
    int step = 0;

    always @(negedge clock) begin
        elem_t acc;
        if (rst_seen) begin
            emit_q.delete();
            out_valid = 1'b0;
            prev_v = '0;
        end else begin
            if (in_valid != '0) begin
                if (prev_v == '0) begin
                    step = 0;
                    for (int i = 0; i < N; i++)
                        for (int s = 0; s < 2*N-1; s++) begin rec_i[i][s] = '0; rec_w[i][s] = '0; end
                end else begin
                    step++;
                end
                if (step < 2*N-1) begin
                    for (int i = 0; i < N; i++) begin
                        rec_i[i][step] = in_valid[i] ? iact_in[i*DW +: DW] : '0;
                        rec_w[i][step] = in_valid[i] ? weight_in[i*DW +: DW] : '0;
                    end
                end
            end
            prev_v = in_valid;
            if (shift_acc && !stub_mode) begin
                for (int b = N*N-1; b >= 0; b--) begin
                    acc = '0;
                    for (int k = 0; k < N; k++) acc = acc + fx(rec_i[b/N][k + b/N], rec_w[b%N][k + b%N]);
                    emit_q.push_back(acc);
                end
            end
            if (emit_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                out_valid = 1'b1;
                data_out = emit_q.pop_front();
            end else if (junk_mode && (in_valid != '0 || ready)) begin
                out_valid = 1'($urandom_range(0, 1));
                data_out = $urandom;
            end else begin
                out_valid = 1'b0;
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dd);
        dd = 0;
        while (dd < budget) begin
            @(negedge clock);
            dd++;
            if (done === 1'b1) break;
        end
        check("done_seen", MW'(done), MW'(1'b1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] vseq [5];
        logic [MW-1:0] ref_a;
        logic [MW-1:0] ref_b;
        int dd;
        int waited;
        vseq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

        reset = 1'b1;
        start = 1'b0;
        // iact {{2,3,8},{6,2,5},{2,3,3}}, weight {{1,2,3},{4,7.5,2},{1,4,4}} in 16.16
        iact_mat = {32'h0003_0000, 32'h0003_0000, 32'h0002_0000,
                    32'h0005_0000, 32'h0002_0000, 32'h0006_0000,
                    32'h0008_0000, 32'h0003_0000, 32'h0002_0000};
        weight_mat = {32'h0004_0000, 32'h0004_0000, 32'h0001_0000,
                      32'h0002_0000, 32'h0007_8000, 32'h0004_0000,
                      32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("rst_ready",    MW'(ready),    MW'(1'b1));
        check("rst_done",     MW'(done),     MW'(1'b0));
        check("rst_in_valid", MW'(in_valid), MW'(3'b000));
        check("rst_result",   result_mat,    '0);
        reset = 1'b0;
        @(negedge clock);

        // Directed run with hand-computed wavefront, shift timing and result.
        do_start();
        for (int d = 1; d <= LAT + 1; d++) begin
            @(negedge clock);
            if (d <= 2*N-1) check("wave_valid_lit", MW'(in_valid), MW'(vseq[d-1]));
            if (d == 2) check("w_lane1_lit", MW'(weight_in[DW +: DW]), MW'(32'h0002_0000));
            if (d >= LAT - 1) check("shift_lit", MW'(shift_acc), MW'(d == LAT));
        end
        wait_done(100, dd);
        check("res0_lit",  MW'(result_mat[0*DW +: DW]), MW'(32'h0016_0000));
        check("res1_lit",  MW'(result_mat[1*DW +: DW]), MW'(32'h003A_8000));
        check("res8_lit",  MW'(result_mat[8*DW +: DW]), MW'(32'h0018_0000));
        check("res_full",  result_mat, ref_prod(iact_mat, weight_mat));
        check("err_lit",   MW'(error), MW'(1'b0));

        // start during FEED with different matrices is ignored.
        iact_mat = rnd_mat(); weight_mat = rnd_mat();
        ref_a = ref_prod(iact_mat, weight_mat);
        do_start();
        for (int d = 1; d <= 3; d++) begin
            @(negedge clock);
            if (d == 2) begin iact_mat = rnd_mat(); weight_mat = rnd_mat(); start = 1'b1; end
            if (d == 3) start = 1'b0;
        end
        wait_done(100, dd);
        check("busy_start_res", result_mat, ref_a);

        // No beats from the array: timeout error, cleared result.
        stub_mode = 1'b1;
        iact_mat = rnd_mat(); weight_mat = rnd_mat();
        do_start();
        wait_done(200, dd);
        check("tmo_latency", MW'(dd),    MW'(LAT + TMO));
        check("tmo_error",   MW'(error), MW'(1'b1));
        check("tmo_result",  result_mat, '0);
        stub_mode = 1'b0;

        // Reset after four collected beats, then a clean run.
        iact_mat = rnd_mat(); weight_mat = rnd_mat();
        do_start();
        waited = 0;
        while (m_beats < 4 && waited < 100) begin @(negedge clock); waited++; end
        check("mid_beats", MW'(m_beats >= 4), MW'(1'b1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mr_ready",  MW'(ready), MW'(1'b1));
        check("mr_done",   MW'(done),  MW'(1'b0));
        check("mr_result", result_mat, '0);
        iact_mat = rnd_mat(); weight_mat = rnd_mat();
        ref_a = ref_prod(iact_mat, weight_mat);
        do_start();
        wait_done(100, dd);
        check("post_rst_res", result_mat, ref_a);

        // start held high: second run accepted right after the first's done.
        iact_mat = rnd_mat(); weight_mat = rnd_mat();
        ref_a = ref_prod(iact_mat, weight_mat);
        start = 1'b1;
        @(negedge clock);
        wait_done(100, dd);
        check("b2b_res1", result_mat, ref_a);
        iact_mat = rnd_mat(); weight_mat = rnd_mat();
        ref_b = ref_prod(iact_mat, weight_mat);
        @(negedge clock);
        check("b2b_accept_done",  MW'(done),  MW'(1'b0));
        check("b2b_accept_ready", MW'(ready), MW'(1'b0));
        start = 1'b0;
        wait_done(100, dd);
        check("b2b_res2", result_mat, ref_b);

        // Random runs with spurious out_valid outside COLLECT.
        junk_mode = 1'b1;
        for (int r = 0; r < 5; r++) begin
            iact_mat = rnd_mat(); weight_mat = rnd_mat();
            ref_a = ref_prod(iact_mat, weight_mat);
            do_start();
            wait_done(100, dd);
            check("rnd_res", result_mat, ref_a);
            check("rnd_err", MW'(error), MW'(1'b0));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        junk_mode = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
